// File: rtl/ibus_prefetch.sv
// ibus_prefetch: instruction prefetch buffer between the CPU instruction master
// and the int_mem instruction bus. Streams sequential words into a small FIFO
// so sequential fetches complete one cycle after the request. A non-sequential
// fetch or a flush discards the buffer. An in-flight memory read whose data is
// no longer wanted is drained (DRAIN) before the refetch is issued.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             pulse: invalidate buffer, discard any in-flight fetch
//   cpu_valid/addr    CPU fetch request (held until cpu_ready), byte address
//   cpu_rdata/ready   fetched word + 1-cycle completion pulse
//   mem_valid/addr    read request to memory (held until mem_ready)
//   mem_rdata/ready   memory read data + 1-cycle completion pulse
module ibus_prefetch #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  localparam int                OFS_W = $clog2(DATA_W/8);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(DATA_W/8);
  localparam logic [DEPTH_W:0]  DEPTH = (DEPTH_W+1)'(1 << DEPTH_W);

  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0]  head_addr, fetch_addr;
  logic [DEPTH_W:0]   count;
  logic               pend, valid_base;
  logic [DEPTH_W-1:0] rd_ptr, wr_ptr;
  logic [DATA_W-1:0]  fifo_q [1<<DEPTH_W];

  logic              resp, head_match, covered, hit, miss, push, issue;
  logic [ADDR_W-1:0] cpu_word;
  logic              unused_low;

  assign unused_low = ^cpu_addr[OFS_W-1:0];
  assign cpu_word   = {cpu_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign mem_valid  = pend;

  always_comb begin
    resp       = pend && mem_ready;
    head_match = cpu_addr[ADDR_W-1:OFS_W] == head_addr[ADDR_W-1:OFS_W];
    // Request already targeted by the stream (in flight, or about to issue
    // once a drain completes): wait instead of redirecting again.
    covered    = (count == '0) && valid_base && head_match;
    // cpu_valid stays high during the cpu_ready cycle with the old address;
    // gating on !cpu_ready keeps that cycle from being seen as a new request.
    hit        = !flush && cpu_valid && !cpu_ready && (count != '0) && head_match;
    miss       = !flush && cpu_valid && !cpu_ready && !hit && !covered;
    push       = (state == RUN) && resp && !flush && !miss;
    issue      = (state == RUN) && valid_base && !pend && (count < DEPTH)
                 && !miss && !flush;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next state: abandon an in-flight read unless it completes this cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if ((miss || flush) && pend && !mem_ready) state_nxt = DRAIN;
      DRAIN:   if (mem_ready) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      mem_addr   <= '0;
      head_addr  <= '0;
      fetch_addr <= '0;
      count      <= '0;
      pend       <= 1'b0;
      valid_base <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      cpu_ready <= hit;
      if (hit) begin
        cpu_rdata <= fifo_q[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
        head_addr <= head_addr + STEP;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;

      if (flush || miss)       count <= '0;
      else if (push && !hit)   count <= count + 1'b1;
      else if (hit && !push)   count <= count - 1'b1;

      // fetch_addr advances at issue so it always points past everything
      // buffered or requested.
      if (resp) pend <= 1'b0;
      if (issue) begin
        pend       <= 1'b1;
        mem_addr   <= fetch_addr;
        fetch_addr <= fetch_addr + STEP;
      end

      if (flush) begin
        valid_base <= 1'b0;
        wr_ptr     <= rd_ptr;
      end else if (miss) begin
        valid_base <= 1'b1;
        head_addr  <= cpu_word;
        fetch_addr <= cpu_word;
        wr_ptr     <= rd_ptr;
      end
    end
  end
endmodule
